// File: rtl/toggle_gate_bank.sv
// toggle_gate_bank
//   A bank of independent push-button switch channels. Each channel
//   synchronises and debounces an active-low button, turns accepted presses
//   into a switch State (toggle or momentary), and gates its data lane with
//   that State.
//
// Ports
//   CLK      in   single clock, rising edge
//   Reset    in   synchronous, active-high reset
//   On_Off   in   [CHANNELS]         raw async buttons, 0 = pressed
//   Clear    in   [CHANNELS]         per-channel synchronous clear, active low
//   Mode     in   [CHANNELS]         0 = toggle, 1 = momentary
//   IN       in   [CHANNELS*DATA_W]  channel data, lane i at [i*DATA_W +: DATA_W]
//   OUT      out  [CHANNELS*DATA_W]  IN lane when State[i] = 1, else zero
//   State    out  [CHANNELS]         switch state, 1 = ON
//   Toggled  out  [CHANNELS]         one-cycle pulse after a press-driven State change
module toggle_gate_bank #(
  parameter int CHANNELS = 4,
  parameter int DATA_W   = 8,
  parameter int DEBOUNCE = 16
) (
  input  logic                       CLK,
  input  logic                       Reset,
  input  logic [CHANNELS-1:0]        On_Off,
  input  logic [CHANNELS-1:0]        Clear,
  input  logic [CHANNELS-1:0]        Mode,
  input  logic [CHANNELS*DATA_W-1:0] IN,
  output logic [CHANNELS*DATA_W-1:0] OUT,
  output logic [CHANNELS-1:0]        State,
  output logic [CHANNELS-1:0]        Toggled
);

  localparam int CNT_W = $clog2(DEBOUNCE);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic             s1_q, s1_d;
      logic             s2_q, s2_d;
      logic             deb_q, deb_d;
      logic             deb_prev_q, deb_prev_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             state_q, state_d;
      logic             toggled_q, toggled_d;
      logic             press;

      always_comb begin
        s1_d      = On_Off[gi];
        s2_d      = s1_q;
        deb_d     = deb_q;
        cnt_d     = '0;
        state_d   = state_q;
        toggled_d = 1'b0;

        // Debounce: count consecutive cycles that disagree with the accepted
        // level; any agreeing cycle restarts the count from zero.
        if (s2_q != deb_q) begin
          if (cnt_q == CNT_MAX) begin
            deb_d = s2_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        // Press = debounced falling edge, seen the cycle after deb falls.
        press = deb_prev_q & ~deb_q;

        // While cleared, keep deb_prev in step with the next deb so a press
        // accepted during Clear leaves no pending edge behind (discarded,
        // not deferred).
        deb_prev_d = Clear[gi] ? deb_q : deb_d;

        if (!Clear[gi]) begin
          state_d = 1'b0;
        end else if (Mode[gi]) begin
          state_d   = ~deb_q;
          toggled_d = (state_d != state_q);
        end else if (press) begin
          state_d   = ~state_q;
          toggled_d = 1'b1;
        end
      end

      always_ff @(posedge CLK) begin
        if (Reset) begin
          s1_q       <= 1'b1;
          s2_q       <= 1'b1;
          deb_q      <= 1'b1;
          deb_prev_q <= 1'b1;
          cnt_q      <= '0;
          state_q    <= 1'b0;
          toggled_q  <= 1'b0;
        end else begin
          s1_q       <= s1_d;
          s2_q       <= s2_d;
          deb_q      <= deb_d;
          deb_prev_q <= deb_prev_d;
          cnt_q      <= cnt_d;
          state_q    <= state_d;
          toggled_q  <= toggled_d;
        end
      end

      assign State[gi]                   = state_q;
      assign Toggled[gi]                 = toggled_q;
      assign OUT[gi*DATA_W +: DATA_W]    = state_q ? IN[gi*DATA_W +: DATA_W] : '0;
    end
  endgenerate

endmodule

// File: tb/tb_toggle_gate_bank.sv
module tb_toggle_gate_bank;

  localparam int CH = 4;
  localparam int DW = 8;
  localparam int DB = 4;

  logic             CLK = 1'b0;
  logic             Reset;
  logic [CH-1:0]    On_Off;
  logic [CH-1:0]    Clear;
  logic [CH-1:0]    Mode;
  logic [CH*DW-1:0] IN;
  logic [CH*DW-1:0] OUT;
  logic [CH-1:0]    State;
  logic [CH-1:0]    Toggled;

  toggle_gate_bank #(.CHANNELS(CH), .DATA_W(DW), .DEBOUNCE(DB)) dut (
    .CLK(CLK), .Reset(Reset), .On_Off(On_Off), .Clear(Clear), .Mode(Mode),
    .IN(IN), .OUT(OUT), .State(State), .Toggled(Toggled)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int           at;
    int           ch;
    logic         st;
    logic         tg;
    logic [DW-1:0] out;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];
  int    cyc = 0;
  int    n_chk = 0;
  int    n_fail = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Queue an expectation for channel ch, to be checked after edge cyc+off.
  task automatic expect_at(input int off, input string tag, input int ch,
                           input logic st, input logic tg);
    exp_t e;
    int   idx;
    e.at  = cyc + off;
    e.ch  = ch;
    e.st  = st;
    e.tg  = tg;
    e.out = st ? IN[ch*DW +: DW] : '0;
    idx = sb_q.size();
    for (int i = 0; i < sb_q.size(); i++) begin
      if (sb_q[i].at > e.at) begin
        idx = i;
        break;
      end
    end
    sb_q.insert(idx, e);
    tag_q.insert(idx, tag);
  endtask

  exp_t  e_m;
  string t_m;
  always @(negedge CLK) begin
    while (sb_q.size() > 0 && sb_q[0].at <= cyc) begin
      e_m = sb_q.pop_front();
      t_m = tag_q.pop_front();
      check_val($sformatf("%s.ch%0d.state", t_m, e_m.ch), 32'(State[e_m.ch]), 32'(e_m.st));
      check_val($sformatf("%s.ch%0d.toggled", t_m, e_m.ch), 32'(Toggled[e_m.ch]), 32'(e_m.tg));
      check_val($sformatf("%s.ch%0d.out", t_m, e_m.ch), 32'(OUT[e_m.ch*DW +: DW]), 32'(e_m.out));
      $display("cycle %0d %s ch%0d state=%0b toggled=%0b out=%02h", cyc, t_m, e_m.ch,
               State[e_m.ch], Toggled[e_m.ch], OUT[e_m.ch*DW +: DW]);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    Reset  = 1'b1;
    On_Off = '1;
    Clear  = '1;
    Mode   = '0;
    IN     = {8'hC3, 8'h5A, 8'h3C, 8'hA5};

    // Reset state
    tick(2);
    for (int c = 0; c < CH; c++) expect_at(0, "reset", c, 1'b0, 1'b0);
    tick(1);
    Reset = 1'b0;
    tick(3);

    // First press on ch0: ON after k+6, OUT = IN
    On_Off[0] = 1'b0;
    expect_at(6, "p1.pre", 0, 1'b0, 1'b0);
    expect_at(7, "p1.on", 0, 1'b1, 1'b1);
    expect_at(8, "p1.hold", 0, 1'b1, 1'b0);
    tick(12);
    On_Off[0] = 1'b1;
    expect_at(10, "p1.release", 0, 1'b1, 1'b0);
    tick(12);

    // Second press on ch0: OFF
    On_Off[0] = 1'b0;
    expect_at(6, "p2.pre", 0, 1'b1, 1'b0);
    expect_at(7, "p2.off", 0, 1'b0, 1'b1);
    expect_at(8, "p2.hold", 0, 1'b0, 1'b0);
    tick(12);
    On_Off[0] = 1'b1;
    tick(12);

    // 3-cycle glitch on ch1 must be ignored
    On_Off[1] = 1'b0;
    for (int k = 1; k <= 12; k++) expect_at(k, "glitch", 1, 1'b0, 1'b0);
    tick(3);
    On_Off[1] = 1'b1;
    tick(12);

    // Momentary ch2: held 10 cycles
    Mode[2] = 1'b1;
    tick(3);
    On_Off[2] = 1'b0;
    expect_at(6, "mom.pre", 2, 1'b0, 1'b0);
    expect_at(7, "mom.on", 2, 1'b1, 1'b1);
    expect_at(8, "mom.hold", 2, 1'b1, 1'b0);
    expect_at(16, "mom.last", 2, 1'b1, 1'b0);
    expect_at(17, "mom.off", 2, 1'b0, 1'b1);
    expect_at(18, "mom.idle", 2, 1'b0, 1'b0);
    tick(10);
    On_Off[2] = 1'b1;
    tick(12);
    Mode[2] = 1'b0;
    tick(2);

    // Clear on ch3 while a press is accepted
    On_Off[3] = 1'b0;
    expect_at(7, "clr.set", 3, 1'b1, 1'b1);
    tick(12);
    On_Off[3] = 1'b1;
    tick(12);
    On_Off[3] = 1'b0;
    for (int k = 5; k <= 12; k++) expect_at(k, "clr", 3, 1'b0, 1'b0);
    tick(4);
    Clear[3] = 1'b0;
    tick(2);
    Clear[3] = 1'b1;
    tick(8);
    On_Off[3] = 1'b1;
    tick(12);

    // Simultaneous presses on all channels
    On_Off = '0;
    for (int c = 0; c < CH; c++) begin
      expect_at(6, "all.pre", c, 1'b0, 1'b0);
      expect_at(7, "all.on", c, 1'b1, 1'b1);
      expect_at(8, "all.hold", c, 1'b1, 1'b0);
    end
    tick(10);
    On_Off = '1;
    tick(12);

    // Reset mid-debounce, held buttons re-accepted afterwards
    On_Off = '0;
    tick(3);
    Reset = 1'b1;
    for (int c = 0; c < CH; c++) begin
      expect_at(1, "rst.a", c, 1'b0, 1'b0);
      expect_at(2, "rst.b", c, 1'b0, 1'b0);
    end
    tick(2);
    Reset = 1'b0;
    for (int c = 0; c < CH; c++) begin
      expect_at(6, "rst.pre", c, 1'b0, 1'b0);
      expect_at(7, "rst.on", c, 1'b1, 1'b1);
      expect_at(8, "rst.hold", c, 1'b1, 1'b0);
    end
    tick(12);
    On_Off = '1;

    // Drain with a bounded wait
    for (int k = 0; k < 50 && sb_q.size() > 0; k++) tick(1);
    check_val("sb.drain", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/toggle_gate_bank.md
TOGGLE_GATE_BANK -- requirements
Module: toggle_gate_bank

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent switch channels (1..32).
REQ-002 Parameter DATA_W, default 8: width of each channel's data path.
REQ-003 Parameter DEBOUNCE, default 16: stable cycles needed to accept a button level (2..65535); counter width = clog2(DEBOUNCE).
REQ-004 CLK  in  1  single clock; all state changes on rising edge.
REQ-005 Reset  in  1  synchronous, active-high reset.
REQ-006 On_Off  in  CHANNELS  raw asynchronous button per channel; active-low (0 = pressed).
REQ-007 Clear  in  CHANNELS  per-channel synchronous clear; active-low level.
REQ-008 Mode  in  CHANNELS  per-channel mode: 0 = toggle, 1 = momentary.
REQ-009 IN  in  CHANNELS*DATA_W  channel data; channel i occupies bits [i*DATA_W +: DATA_W].
REQ-010 OUT  out  CHANNELS*DATA_W  gated channel data, same packing as IN.
REQ-011 State  out  CHANNELS  current switch state per channel (1 = ON).
REQ-012 Toggled  out  CHANNELS  one-cycle pulse per channel when a press changes State.

Function
REQ-013 Each On_Off bit SHALL pass through a two-flop synchroniser (s1, s2) before any other use.
REQ-014 Each channel SHALL hold a debounced level deb[i] and a counter cnt[i]; if s2 == deb, cnt SHALL be 0.
REQ-015 If s2 != deb and cnt < DEBOUNCE-1, cnt SHALL increment; if s2 != deb and cnt == DEBOUNCE-1, deb SHALL take s2 and cnt SHALL return to 0.
REQ-016 Any return of s2 to deb before acceptance SHALL zero cnt; glitches shorter than DEBOUNCE cycles SHALL have no effect.
REQ-017 A press event SHALL be a 1->0 transition of deb. A 0->1 transition (release) SHALL NOT be a press.
REQ-018 Toggle mode: each press event SHALL invert State[i] on the next rising edge.
REQ-019 Momentary mode: State[i] SHALL be registered ~deb[i], so it is ON while the debounced button is held.
REQ-020 Latency: with On_Off held low from the edge that first samples it (edge k), deb SHALL fall at edge k+DEBOUNCE+1. State SHALL update at edge k+DEBOUNCE+2.
REQ-021 Toggled[i] SHALL be high for exactly the cycle after any State[i] change caused by a press or momentary follow. It SHALL NOT pulse for changes caused by Clear or Reset.
REQ-022 Clear[i] low SHALL force State[i] to 0 at the next edge. It overrides a simultaneous press or momentary hold. Debounce logic SHALL keep running during Clear.
REQ-023 A press accepted while Clear[i] is low SHALL be discarded, not deferred.
REQ-024 Mode change toggle->momentary: State SHALL follow ~deb from the next edge. Mode change momentary->toggle: State SHALL keep its value until the next press.
REQ-025 OUT channel i SHALL equal IN channel i when State[i] = 1, else all zeros. OUT SHALL be combinational from State and IN, with no added latency.
REQ-026 Channels SHALL be fully independent. Simultaneous presses on several channels SHALL each take effect in the same cycle.

Reset
REQ-027 While Reset = 1 at an edge: s1, s2 and deb = 1 (released); cnt = 0; State = 0; Toggled = 0; OUT = 0.
REQ-028 Reset SHALL take priority over Clear, press and Mode at every edge. A press in progress SHALL be abandoned.
REQ-029 After Reset deasserts, a button already held low SHALL be treated as a new press after the full REQ-020 latency.

Verification
REQ-030 DEBOUNCE=4, Mode=0, hold On_Off[0] low from edge k -> State[0]=1 and Toggled[0] pulse after edge k+6; OUT[7:0] = IN[7:0] (e.g. 0xA5).
REQ-031 Release, then a second press -> State[0]=0, OUT[7:0]=0x00. A 3-cycle low glitch on On_Off[1] -> State[1] unchanged, no Toggled pulse.
REQ-032 Mode[2]=1, hold On_Off[2] low 10 cycles -> State[2]=1 from edge k+6 until 6 edges after release, then 0.
REQ-033 State[3]=1; Clear[3] low in the same cycle a press is accepted -> State[3]=0, Toggled[3] stays 0, no later toggle.
REQ-034 Presses on all channels at once -> all States invert together. Assert Reset mid-debounce -> all outputs 0, cnt 0; the held button is re-accepted 6 edges after Reset falls.
